// File: rtl/dmg_dma_pkg.sv
// Shared types and constants for the OAM DMA engine: FSM state encoding,
// transfer geometry, register address and the echo-RAM source mapping.
package dmg_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2
  } dma_state_t;

  localparam int         DMA_XFER_LEN = 160;
  localparam logic [7:0] DMA_REG_ADDR = 8'h46;

  // Pages E0..FF alias work RAM at C0..DF.
  function automatic logic [7:0] echo_map(input logic [7:0] hi);
    return (hi >= 8'hE0) ? hi - 8'h20 : hi;
  endfunction

endpackage

// File: rtl/oam_dma_if.sv
// SoC-side bus bundle for the OAM DMA engine: CPU register port, source
// read port, OAM write port, arbiter block and debug state.
interface oam_dma_if;
  import dmg_dma_pkg::*;

  // Handshake: no valid/ready; every transfer is qualified by mcyc. CPU
  // soc_wr/soc_rd count only on a clk with mcyc=1, dma_din is sampled on that
  // clk while dma_rd=1, and oam_wr is a one-clk pulse after the mcyc edge.
  logic        mcyc;
  logic        ffxx;
  logic [7:0]  a;
  logic        soc_wr;
  logic        soc_rd;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        reg_sel;
  logic [15:0] dma_a;
  logic        dma_rd;
  logic [7:0]  dma_din;
  logic [7:0]  oam_a;
  logic [7:0]  oam_d;
  logic        oam_wr;
  logic        dma_active;
  logic        cpu_block;
  dma_state_t  dbg_state;

  modport master (
    output mcyc, ffxx, a, soc_wr, soc_rd, d_in, dma_din,
    input  d_out, reg_sel, dma_a, dma_rd, oam_a, oam_d, oam_wr,
           dma_active, cpu_block, dbg_state
  );

  modport slave (
    input  mcyc, ffxx, a, soc_wr, soc_rd, d_in, dma_din,
    output d_out, reg_sel, dma_a, dma_rd, oam_a, oam_d, oam_wr,
           dma_active, cpu_block, dbg_state
  );
endinterface

// File: rtl/dma_index_counter.sv
// Byte index for the OAM copy: clears or advances only on mcyc and saturates
// at the last index so it can never wrap past the end of OAM.
module dma_index_counter
  import dmg_dma_pkg::*;
#(
  parameter int XFER_LEN = DMA_XFER_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mcyc,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] idx,
  output logic       tc
);

  assign tc = (idx == 8'(XFER_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 8'h00;
    end else if (mcyc) begin
      if (clear) begin
        idx <= 8'h00;
      end else if (inc && !tc) begin
        idx <= idx + 8'h01;
      end
    end
  end

endmodule

// File: rtl/oam_dma.sv
// OAM DMA engine at FF46: copies XFER_LEN bytes from {page,00..} into OAM,
// one byte per M-cycle, and asks the arbiter to block non-FFxx CPU cycles.
module oam_dma
  import dmg_dma_pkg::*;
#(
  parameter int         XFER_LEN    = DMA_XFER_LEN,
  parameter logic [7:0] REG_ADDR    = DMA_REG_ADDR,
  parameter int         START_DELAY = 1
) (
  input logic      clk,
  input logic      rst,
  oam_dma_if.slave bus
);

  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(START_DELAY - 1);

  dma_state_t     state;
  logic [7:0]     src_hi;
  logic [7:0]     src_map;
  logic [DLY_W-1:0] dly_cnt;
  logic           dma_rd_q;
  logic           active_q;
  logic           oam_wr_q;
  logic [7:0]     oam_a_q;
  logic [7:0]     oam_d_q;
  logic [7:0]     idx;
  logic           tc;
  logic           reg_sel;
  logic           reg_wr;
  logic           idx_clear;
  logic           idx_inc;

  assign reg_sel   = bus.ffxx && (bus.a == REG_ADDR);
  assign reg_wr    = bus.mcyc && bus.soc_wr && reg_sel;
  assign idx_clear = (state == ST_START) && !reg_wr && (dly_cnt == '0);
  assign idx_inc   = (state == ST_XFER);

  dma_index_counter #(.XFER_LEN(XFER_LEN)) u_idx (
    .clk   (clk),
    .rst   (rst),
    .mcyc  (bus.mcyc),
    .clear (idx_clear),
    .inc   (idx_inc),
    .idx   (idx),
    .tc    (tc)
  );

  // src_map is frozen for the running copy, so a restart keeps reading the old
  // page until the new transfer actually begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      src_hi   <= 8'h00;
      src_map  <= 8'h00;
      dly_cnt  <= '0;
      dma_rd_q <= 1'b0;
      active_q <= 1'b0;
      oam_wr_q <= 1'b0;
      oam_a_q  <= 8'h00;
      oam_d_q  <= 8'h00;
    end else begin
      oam_wr_q <= 1'b0;
      if (bus.mcyc) begin
        if (reg_wr) src_hi <= bus.d_in;
        case (state)
          ST_IDLE: begin
            if (reg_wr) begin
              state    <= ST_START;
              dly_cnt  <= DLY_INIT;
              active_q <= 1'b1;
            end
          end
          ST_START: begin
            if (reg_wr) begin
              dly_cnt <= DLY_INIT;
            end else if (dly_cnt == '0) begin
              state    <= ST_XFER;
              src_map  <= echo_map(src_hi);
              dma_rd_q <= 1'b1;
            end else begin
              dly_cnt <= dly_cnt - 1'b1;
            end
          end
          ST_XFER: begin
            oam_wr_q <= 1'b1;
            oam_a_q  <= idx;
            oam_d_q  <= bus.dma_din;
            if (reg_wr) begin
              state    <= ST_START;
              dly_cnt  <= DLY_INIT;
              dma_rd_q <= !tc;
            end else if (tc) begin
              state    <= ST_IDLE;
              dma_rd_q <= 1'b0;
              active_q <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.reg_sel    = reg_sel;
  assign bus.d_out      = (reg_sel && bus.soc_rd) ? src_hi : 8'h00;
  assign bus.dma_a      = {src_map, idx};
  assign bus.dma_rd     = dma_rd_q;
  assign bus.oam_a      = oam_a_q;
  assign bus.oam_d      = oam_d_q;
  assign bus.oam_wr     = oam_wr_q;
  assign bus.dma_active = active_q;
  assign bus.cpu_block  = active_q;
  assign bus.dbg_state  = state;

endmodule
